decode_queue: RTL and testbench

Decode queue between the 2-wide decoder and the schedule unit. Stores decoded instruction pairs in a circular FIFO and presents the oldest pair show-ahead to the scheduler. Pops one pair per accepted scheduler request and confirms it with a registered ack. Applies backpressure to the decoder when full and clears on a pipeline flush.

---
 rtl/decode_queue.sv | 125 ++++++++++++
 tb/tb_decode_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Decode queue: circular FIFO of decoded instruction pairs between the
// 2-wide decoder and the scheduler. The oldest pair is presented show-ahead.
// A registered ack confirms each accepted pop, and a flush empties the queue.

package decode_queue_pkg;

  // One decoded instruction. Only .valid has meaning to the queue itself.
  typedef struct packed {
    logic        valid;
    logic [7:0]  op;
    logic [15:0] tag;
  } decode_t;

endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_flush,
  input  logic                     i_dec_dque_valid,
  input  decode_t                  i_dec_decode_0,
  input  decode_t                  i_dec_decode_1,
  output logic                     o_dque_dec_ready,
  input  logic                     i_sch_dque_request,
  output logic                     o_dque_sch_ready,
  output logic                     o_dque_sch_ack,
  output decode_t                  o_dque_sch_decode_0,
  output decode_t                  o_dque_sch_decode_1,
  output logic [$clog2(DEPTH):0]   o_dque_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;

  // Older and younger instruction of each slot kept in parallel arrays.
  decode_t mem0_q [DEPTH];
  decode_t mem1_q [DEPTH];

  logic push;
  logic pop;
  logic not_full;
  logic not_empty;

  // Handshake qualification; ready flags depend on stored state only.
  always_comb begin
    not_full  = (count_q != FULL_COUNT);
    not_empty = (count_q != '0);
    // A pair with neither instruction valid is dropped without using a slot.
    push = i_dec_dque_valid & not_full
         & (i_dec_decode_0.valid | i_dec_decode_1.valid) & ~i_flush;
    pop  = i_sch_dque_request & not_empty & ~i_flush;
  end

  // Next-state for pointers, occupancy and ack; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ack_d    = pop;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ack_d    = 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
    end
  end

  // Pair storage; contents are not reset, only the pointers qualify them.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem0_q[wr_ptr_q] <= i_dec_decode_0;
      mem1_q[wr_ptr_q] <= i_dec_decode_1;
    end
  end

  // Show-ahead head read; valid bits masked while the queue is empty.
  always_comb begin
    o_dque_sch_decode_0 = mem0_q[rd_ptr_q];
    o_dque_sch_decode_1 = mem1_q[rd_ptr_q];
    if (!not_empty) begin
      o_dque_sch_decode_0.valid = 1'b0;
      o_dque_sch_decode_1.valid = 1'b0;
    end
  end

  assign o_dque_dec_ready = not_full;
  assign o_dque_sch_ready = not_empty;
  assign o_dque_sch_ack   = ack_q;
  assign o_dque_count     = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: vector table plus hand-written sequences
// for fill/wrap, and asynchronous reset mid-operation.

module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 8;

  logic     clk;
  logic     rstn;
  logic     flush;
  logic     dvalid;
  decode_t  d0, d1;
  logic     dec_ready;
  logic     req;
  logic     sch_ready;
  logic     ack;
  decode_t  h0, h1;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .i_clk               (clk),
    .i_rstn              (rstn),
    .i_flush             (flush),
    .i_dec_dque_valid    (dvalid),
    .i_dec_decode_0      (d0),
    .i_dec_decode_1      (d1),
    .o_dque_dec_ready    (dec_ready),
    .i_sch_dque_request  (req),
    .o_dque_sch_ready    (sch_ready),
    .o_dque_sch_ack      (ack),
    .o_dque_sch_decode_0 (h0),
    .o_dque_sch_decode_1 (h1),
    .o_dque_count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       valid;
    logic       req;
    decode_t    d0;
    decode_t    d1;
    logic       e_dready;
    logic       e_sready;
    logic       e_ack;
    logic [3:0] e_count;
    decode_t    e_h0;
    decode_t    e_h1;
  } vec_t;

  vec_t vecs[$];

  function automatic decode_t mk(input logic v, input logic [15:0] t);
    decode_t r;
    r.valid = v;
    r.op    = t[7:0] ^ 8'h5A;
    r.tag   = t;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic v, input logic r,
                       input decode_t a, input decode_t b);
    flush = f; dvalid = v; req = r; d0 = a; d1 = b;
  endtask

  // Add a vector: pair tag t gives d0=(v0,t), d1=(v1,t+1); head tag h.
  task automatic addv(input logic f, input logic v, input logic r,
                      input logic v0, input logic v1, input logic [15:0] t,
                      input logic edr, input logic esr, input logic eack,
                      input logic [3:0] ecnt,
                      input logic hv0, input logic hv1, input logic [15:0] h);
    vec_t x;
    x.flush = f; x.valid = v; x.req = r;
    x.d0 = mk(v0, t); x.d1 = mk(v1, t + 16'd1);
    x.e_dready = edr; x.e_sready = esr; x.e_ack = eack; x.e_count = ecnt;
    x.e_h0 = mk(hv0, h); x.e_h1 = mk(hv1, h + 16'd1);
    vecs.push_back(x);
  endtask

  task automatic chk_head(input string name, input logic [15:0] h);
    chk({name, ".h0"}, 32'(h0), 32'(mk(1'b1, h)));
    chk({name, ".h1"}, 32'(h1), 32'(mk(1'b1, h + 16'd1)));
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, mk(1'b0, 16'h0), mk(1'b0, 16'h0));
    #12;
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.sready", 32'(sch_ready), 32'd0);
    chk("rst.dready", 32'(dec_ready), 32'd1);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.h0v", 32'(h0.valid), 32'd0);
    chk("rst.h1v", 32'(h1.valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    //    f  v  r  v0 v1 tag      dr sr ack cnt hv0 hv1 head
    addv(0, 1, 0, 1, 1, 16'h10, 1, 1, 0, 1, 1, 1, 16'h10); // push A
    addv(0, 1, 0, 1, 1, 16'h20, 1, 1, 0, 2, 1, 1, 16'h10); // push B
    addv(0, 0, 1, 1, 1, 16'h00, 1, 1, 1, 1, 1, 1, 16'h20); // pop A
    addv(0, 0, 1, 1, 1, 16'h00, 1, 0, 1, 0, 0, 0, 16'h00); // pop B
    addv(0, 0, 0, 1, 1, 16'h00, 1, 0, 0, 0, 0, 0, 16'h00); // idle
    addv(0, 1, 0, 0, 0, 16'h70, 1, 0, 0, 0, 0, 0, 16'h00); // empty pair dropped
    addv(0, 1, 0, 1, 0, 16'h30, 1, 1, 0, 1, 1, 0, 16'h30); // only d0 valid
    addv(0, 1, 1, 1, 1, 16'h40, 1, 1, 1, 1, 1, 1, 16'h40); // push+pop at 1
    addv(0, 0, 1, 1, 1, 16'h00, 1, 0, 1, 0, 0, 0, 16'h00); // pop C
    addv(0, 1, 1, 1, 1, 16'h50, 1, 1, 0, 1, 1, 1, 16'h50); // req empty + push D
    addv(0, 1, 0, 1, 1, 16'h60, 1, 1, 0, 2, 1, 1, 16'h50); // push E
    addv(0, 1, 0, 1, 1, 16'h80, 1, 1, 0, 3, 1, 1, 16'h50); // push F
    addv(0, 1, 1, 1, 1, 16'h90, 1, 1, 1, 3, 1, 1, 16'h60); // count 3 push+pop
    addv(0, 1, 0, 1, 1, 16'hA0, 1, 1, 0, 4, 1, 1, 16'h60); // push
    addv(0, 1, 0, 1, 1, 16'hB0, 1, 1, 0, 5, 1, 1, 16'h60); // push -> 5
    addv(1, 1, 1, 1, 1, 16'hC0, 1, 0, 0, 0, 0, 0, 16'h00); // flush wins
    addv(0, 0, 0, 1, 1, 16'h00, 1, 0, 0, 0, 0, 0, 16'h00); // stays empty

    for (int i = 0; i < vecs.size(); i++) begin
      string n;
      n = $sformatf("v%0d", i);
      drive(vecs[i].flush, vecs[i].valid, vecs[i].req, vecs[i].d0, vecs[i].d1);
      step();
      chk({n, ".count"}, 32'(count), 32'(vecs[i].e_count));
      chk({n, ".sready"}, 32'(sch_ready), 32'(vecs[i].e_sready));
      chk({n, ".dready"}, 32'(dec_ready), 32'(vecs[i].e_dready));
      chk({n, ".ack"}, 32'(ack), 32'(vecs[i].e_ack));
      if (vecs[i].e_sready) begin
        chk({n, ".h0"}, 32'(h0), 32'(vecs[i].e_h0));
        chk({n, ".h1"}, 32'(h1), 32'(vecs[i].e_h1));
      end else begin
        chk({n, ".h0v"}, 32'(h0.valid), 32'd0);
        chk({n, ".h1v"}, 32'(h1.valid), 32'd0);
      end
      $display("vec %0d: f=%0b v=%0b r=%0b -> count=%0d sready=%0b dready=%0b ack=%0b head=%0h",
               i, vecs[i].flush, vecs[i].valid, vecs[i].req, count, sch_ready,
               dec_ready, ack, h0.tag);
    end

    // Fill to DEPTH with no requests.
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b1, 1'b0, mk(1'b1, 16'h100 + 16'(2*k)), mk(1'b1, 16'h101 + 16'(2*k)));
      step();
      chk($sformatf("fill%0d.count", k), 32'(count), 32'(k + 1));
      chk($sformatf("fill%0d.dready", k), 32'(dec_ready), (k < DEPTH - 1) ? 32'd1 : 32'd0);
      $display("fill %0d: count=%0d dready=%0b", k, count, dec_ready);
    end
    // Ninth pair offered while full: ignored.
    drive(1'b0, 1'b1, 1'b0, mk(1'b1, 16'h200), mk(1'b1, 16'h201));
    step();
    chk("full.count", 32'(count), 32'd8);
    chk("full.dready", 32'(dec_ready), 32'd0);
    chk_head("full", 16'h100);
    $display("full hold: count=%0d head=%0h", count, h0.tag);
    // Pop while still offering: pop accepted, push still blocked this cycle.
    req = 1'b1;
    step();
    chk("fpop.count", 32'(count), 32'd7);
    chk("fpop.dready", 32'(dec_ready), 32'd1);
    chk("fpop.ack", 32'(ack), 32'd1);
    chk_head("fpop", 16'h102);
    $display("full pop: count=%0d ack=%0b head=%0h", count, ack, h0.tag);
    // Held ninth pair now accepted, written into the wrapped slot 0.
    req = 1'b0;
    step();
    chk("wrap.count", 32'(count), 32'd8);
    chk("wrap.ack", 32'(ack), 32'd0);
    $display("wrap push: count=%0d ack=%0b", count, ack);
    // Drain back to back: ack stays high, order preserved across the wrap.
    dvalid = 1'b0;
    req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk($sformatf("drain%0d.count", i), 32'(count), 32'(7 - i));
      chk($sformatf("drain%0d.ack", i), 32'(ack), 32'd1);
      if (i < 6)       chk_head($sformatf("drain%0d", i), 16'h104 + 16'(2*i));
      else if (i == 6) chk_head("drain6", 16'h200);
      else             chk("drain7.h0v", 32'(h0.valid), 32'd0);
      $display("drain %0d: count=%0d ack=%0b head=%0h", i, count, ack, h0.tag);
    end
    step();
    chk("drained.ack", 32'(ack), 32'd0);
    chk("drained.sready", 32'(sch_ready), 32'd0);
    $display("drained: ack=%0b sready=%0b", ack, sch_ready);

    // Asynchronous reset mid-operation.
    drive(1'b0, 1'b1, 1'b0, mk(1'b1, 16'h300), mk(1'b1, 16'h301));
    step();
    step();
    req = 1'b1;
    dvalid = 1'b0;
    step();
    chk("pre_rst.count", 32'(count), 32'd1);
    chk("pre_rst.ack", 32'(ack), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.ack", 32'(ack), 32'd0);
    chk("async_rst.sready", 32'(sch_ready), 32'd0);
    chk("async_rst.dready", 32'(dec_ready), 32'd1);
    $display("async reset: count=%0d ack=%0b", count, ack);
    req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("post_rst.count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
